microsequencer: RTL

//  Parametrised successor to the fixed 16-bit PC/T-state pair in the CPU top.

---
 rtl/microsequencer_if.sv | 64 ++++++
 rtl/microsequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/microsequencer_if.sv
// ---------------------------------------------------------------------------
// microsequencer_if
//   Bundles the control, flag and bus signals exchanged between the control
//   decoder (master side) and the microsequencer (slave side).
//
// Parameters
//   ADDR_W  width of the program counter and the bus_in jump target
//   T_W     width of the T-state counter
//
// Signals
//   bus_in     jump/call target from the bus                (master -> slave)
//   rt         reset T-state to 0 at the next edge          (master -> slave)
//   pp         increment PC                                 (master -> slave)
//   jc,jz      jump if carry / if zero                      (master -> slave)
//   jgt,jlt    jump if greater-than / if less-than          (master -> slave)
//   c_flag     ALU carry                                    (master -> slave)
//   z_flag     ALU zero                                     (master -> slave)
//   lt_flag    ALU less-than                                (master -> slave)
//   mem_wait   freeze all sequencer state this cycle        (master -> slave)
//   call,ret   push-and-jump / pop the return stack         (master -> slave)
//   pc         current program counter                      (slave -> master)
//   t          current T-state                              (slave -> master)
//   jmp        jump condition true this cycle (comb.)       (slave -> master)
//   stack_err  sticky return-stack overflow/underflow flag  (slave -> master)
// ---------------------------------------------------------------------------
interface microsequencer_if #(
  parameter int ADDR_W = 16,
  parameter int T_W    = 3
);

  logic [ADDR_W-1:0] bus_in;
  logic              rt;
  logic              pp;
  logic              jc;
  logic              jz;
  logic              jgt;
  logic              jlt;
  logic              c_flag;
  logic              z_flag;
  logic              lt_flag;
  logic              mem_wait;
  logic              call;
  logic              ret;

  logic [ADDR_W-1:0] pc;
  logic [T_W-1:0]    t;
  logic              jmp;
  logic              stack_err;

  // Control decoder side: drives control bits and flags, observes PC/T.
  modport master (
    output bus_in, rt, pp, jc, jz, jgt, jlt,
    output c_flag, z_flag, lt_flag, mem_wait, call, ret,
    input  pc, t, jmp, stack_err
  );

  // Sequencer side: consumes control bits and flags, owns PC/T.
  modport slave (
    input  bus_in, rt, pp, jc, jz, jgt, jlt,
    input  c_flag, z_flag, lt_flag, mem_wait, call, ret,
    output pc, t, jmp, stack_err
  );

endinterface

// File: rtl/microsequencer.sv
// ---------------------------------------------------------------------------
// microsequencer
//   Program counter, T-state counter and jump-condition evaluation for the
//   CPU. Replaces the fixed 16-bit PC/T-state pair with a parametrised block
//   that also supports a memory-wait stall and an optional hardware
//   call/return stack.
//
// Configuration macro
//   USEQ_RETURN_STACK_EN  when defined, call/ret use a STACK_DEPTH-entry
//                         return stack and stack_err reports overflow or
//                         underflow. When undefined, call/ret are ignored,
//                         no stack storage exists and stack_err is tied 0.
//
// Parameters
//   ADDR_W       width of PC and bus_in
//   T_W          width of the T-state counter
//   T_MAX        last T-state before wrapping to 0 (must be < 2**T_W)
//   RESET_PC     PC value after reset
//   STACK_DEPTH  return-stack entries (stack build only)
//
// Ports
//   clk    clock, all state updates on the rising edge
//   reset  asynchronous, active-high reset
//   useq   microsequencer_if slave modport (control in, PC/T/jmp out)
// ---------------------------------------------------------------------------
module microsequencer #(
  parameter int ADDR_W      = 16,
  parameter int T_W         = 3,
  parameter int T_MAX       = 7,
  parameter int RESET_PC    = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  microsequencer_if.slave    useq
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_inc;
  logic [T_W-1:0]    t_q;
  logic [T_W-1:0]    t_next;
  logic              jmp;

  // Jump condition is purely combinational so the decoder can see it in the
  // same cycle, even while the sequencer is held in reset.
  assign jmp = (useq.jc  & useq.c_flag)
             | (useq.jz  & useq.z_flag)
             | (useq.jgt & ~useq.z_flag & ~useq.lt_flag)
             | (useq.jlt & useq.lt_flag);

  // Natural wrap of the ADDR_W-bit adder gives the all-ones -> 0 rollover.
  assign pc_inc = pc_q + ADDR_W'(1);

  assign useq.pc  = pc_q;
  assign useq.t   = t_q;
  assign useq.jmp = jmp;

  // T-state sequencing: rt forces 0, otherwise count up and wrap after T_MAX.
  // A memory wait freezes the counter regardless of rt.
  always_comb begin
    t_next = t_q;
    if (!useq.mem_wait) begin
      if (useq.rt) begin
        t_next = '0;
      end else if (t_q == T_W'(T_MAX)) begin
        t_next = '0;
      end else begin
        t_next = t_q + T_W'(1);
      end
    end
  end

`ifdef USEQ_RETURN_STACK_EN
  // The stack pointer counts occupied entries, so it needs one more code than
  // there are entries to distinguish "full" from "empty".
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q;
  logic [SP_W-1:0]   sp_next;
  logic              err_q;
  logic              err_next;
  logic              push;
  logic              stack_empty;
  logic              stack_full;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;

  assign stack_empty    = (sp_q == '0);
  assign stack_full     = (sp_q == SP_W'(STACK_DEPTH));
  assign push_idx       = IDX_W'(sp_q);
  assign top_idx        = IDX_W'(sp_q - SP_W'(1));
  assign useq.stack_err = err_q;
`else
  // Without the stack, call/ret are accepted on the port list only for pin
  // compatibility; they are folded into a sink so nothing depends on them.
  logic [STACK_DEPTH-1:0] unused_stack_ports;

  assign unused_stack_ports = {STACK_DEPTH{useq.call ^ useq.ret}};
  assign useq.stack_err     = 1'b0;
`endif

  // PC selection in priority order: ret > call > jmp > pp > hold.
  // A stalled cycle commits nothing, including stack pushes/pops and errors.
  // Overflowing call or underflowing ret still advances the PC so the program
  // falls through to the next instruction instead of locking up.
  always_comb begin
    pc_next = pc_q;
`ifdef USEQ_RETURN_STACK_EN
    sp_next  = sp_q;
    err_next = err_q;
    push     = 1'b0;
`endif
    if (!useq.mem_wait) begin
`ifdef USEQ_RETURN_STACK_EN
      if (useq.ret) begin
        if (stack_empty) begin
          pc_next  = pc_inc;
          err_next = 1'b1;
        end else begin
          pc_next = stack_mem[top_idx];
          sp_next = sp_q - SP_W'(1);
        end
      end else if (useq.call) begin
        if (stack_full) begin
          pc_next  = pc_inc;
          err_next = 1'b1;
        end else begin
          pc_next = useq.bus_in;
          sp_next = sp_q + SP_W'(1);
          push    = 1'b1;
        end
      end else
`endif
      if (jmp) begin
        pc_next = useq.bus_in;
      end else if (useq.pp) begin
        pc_next = pc_inc;
      end
    end
  end

  // PC and T-state registers; reset may arrive at any time, even mid-stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= ADDR_W'(RESET_PC);
      t_q  <= '0;
    end else begin
      pc_q <= pc_next;
      t_q  <= t_next;
    end
  end

`ifdef USEQ_RETURN_STACK_EN
  // Return stack storage, pointer and sticky error flag. The pushed value is
  // the address after the call, which is where the matching ret resumes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_mem[i] <= '0;
      end
    end else begin
      sp_q  <= sp_next;
      err_q <= err_next;
      if (push) begin
        stack_mem[push_idx] <= pc_inc;
      end
    end
  end
`endif

endmodule
